// File: rtl/ins_encoder_if.sv
// Instruction-word stream between the parameter encoder and its consumer.
interface ins_encoder_if;
    logic [15:0] ins;
    logic        ins_valid;
    logic        ins_ready;

    modport master (output ins, output ins_valid, input ins_ready);
    modport slave  (input ins, input ins_valid, output ins_ready);
endinterface

// File: rtl/ins_encoder.sv
// Packs four 12-bit parameters into {2'b00, code, data} words and streams the
// pending ones in round-robin order, one word per transfer.
module ins_encoder #(
    parameter bit CHANGE_ONLY = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [11:0]          i1,
    input  logic [11:0]          i2,
    input  logic [11:0]          i3,
    input  logic [11:0]          i4,
    input  logic                 load,
    input  logic                 refresh,
    output logic                 busy,
    ins_encoder_if.master        bus
);
    typedef enum logic {ST_IDLE, ST_SEND} state_t;

    state_t            state_q, state_d;
    logic [3:0][11:0]  p_q, p_d;
    logic [3:0][11:0]  s_q, s_d;
    logic [3:0]        dirty_q, dirty_d;
    logic [1:0]        rr_q, rr_d;
    logic [15:0]       ins_q, ins_d;
    logic              busy_q, busy_d;

    logic [3:0][11:0]  smp;
    logic [3:0]        dirty_rot;
    logic [1:0]        sel_off;
    logic [1:0]        sel_code;
    logic              sel_found;
    logic              sel_en;
    logic [3:0]        sel_mask;

    assign smp = {i4, i3, i2, i1};

    // Rotate so bit 0 is the channel at rr; the lowest set bit is the winner.
    always_comb begin
        dirty_rot = 4'({dirty_q, dirty_q} >> rr_q);
        sel_off   = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (dirty_rot[k]) begin
                sel_off = 2'(k);
            end
        end
        sel_found = |dirty_q;
        sel_code  = rr_q + sel_off;
        sel_en    = (state_q == ST_IDLE) || bus.ins_ready;
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_sel
        assign sel_mask[gi] = sel_en && sel_found && (sel_code == 2'(gi));
    end

    always_comb begin
        state_d = state_q;
        ins_d   = ins_q;
        rr_d    = rr_q;
        s_d     = s_q;
        p_d     = p_q;
        if (sel_en) begin
            if (sel_found) begin
                ins_d          = {2'b00, sel_code, p_q[sel_code]};
                s_d[sel_code]  = p_q[sel_code];
                rr_d           = sel_code + 2'd1;
                state_d        = ST_SEND;
            end else begin
                state_d = ST_IDLE;
            end
        end

        // The load compare runs against the shadow after this edge's selection.
        dirty_d = dirty_q & ~sel_mask;
        if (load) begin
            p_d = smp;
            for (int k = 0; k < 4; k++) begin
                dirty_d[k] = (CHANGE_ONLY == 1'b0) || (smp[k] != s_d[k]);
            end
        end
        if (refresh) begin
            dirty_d = 4'hF;
        end
        busy_d = (state_d == ST_SEND) || (|dirty_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            p_q     <= '0;
            s_q     <= '0;
            dirty_q <= '0;
            rr_q    <= '0;
            ins_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            s_q     <= s_d;
            dirty_q <= dirty_d;
            rr_q    <= rr_d;
            ins_q   <= ins_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.ins       = ins_q;
    assign bus.ins_valid = (state_q == ST_SEND);
    assign busy          = busy_q;
endmodule

// File: tb/tb_ins_encoder.sv
// Scoreboard bench: a CHANGE_ONLY=1 and a CHANGE_ONLY=0 encoder share stimulus
// and are checked against a per-edge reference model plus directed word lists.
module tb_ins_encoder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] i1 = '0, i2 = '0, i3 = '0, i4 = '0;
    logic        load = 1'b0, refresh = 1'b0, ins_ready = 1'b0;
    logic        busy_a, busy_b;

    always #5 clk = ~clk;

    ins_encoder_if if_a ();
    ins_encoder_if if_b ();
    assign if_a.ins_ready = ins_ready;
    assign if_b.ins_ready = ins_ready;

    ins_encoder #(.CHANGE_ONLY(1'b1)) dut_a (
        .clk(clk), .rst(rst), .i1(i1), .i2(i2), .i3(i3), .i4(i4),
        .load(load), .refresh(refresh), .busy(busy_a), .bus(if_a.master)
    );
    ins_encoder #(.CHANGE_ONLY(1'b0)) dut_b (
        .clk(clk), .rst(rst), .i1(i1), .i2(i2), .i3(i3), .i4(i4),
        .load(load), .refresh(refresh), .busy(busy_b), .bus(if_b.master)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state, index 0 = change-only encoder, 1 = send-all encoder.
    logic [11:0] m_p[2][4];
    logic [11:0] m_s[2][4];
    logic        m_d[2][4];
    int          m_rr[2];
    logic        m_v[2];
    logic [15:0] exp_a[$], exp_b[$], seen_a[$], seen_b[$];
    logic        hold[2];
    logic [15:0] prev[2];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endtask

    function automatic logic mbusy(int k);
        return m_v[k] | m_d[k][0] | m_d[k][1] | m_d[k][2] | m_d[k][3];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int n = 0; n < 4; n++) begin
                m_p[k][n] = '0;
                m_s[k][n] = '0;
                m_d[k][n] = 1'b0;
            end
            m_rr[k] = 0;
            m_v[k]  = 1'b0;
        end
        exp_a.delete();
        exp_b.delete();
    endtask

    // One rising edge of the behavioural model, using the inputs held across it.
    task automatic model_edge();
        logic [11:0] smp[4];
        logic [15:0] w;
        logic [1:0]  c2;
        int          found;
        smp[0] = i1; smp[1] = i2; smp[2] = i3; smp[3] = i4;
        for (int k = 0; k < 2; k++) begin
            if (!m_v[k] || ins_ready) begin
                found = -1;
                for (int j = 0; j < 4; j++) begin
                    if (found < 0 && m_d[k][(m_rr[k] + j) % 4]) found = (m_rr[k] + j) % 4;
                end
                if (found >= 0) begin
                    c2 = 2'(found);
                    w  = {2'b00, c2, m_p[k][found]};
                    m_s[k][found] = m_p[k][found];
                    m_d[k][found] = 1'b0;
                    m_rr[k] = (found + 1) % 4;
                    m_v[k]  = 1'b1;
                    if (k == 0) exp_a.push_back(w);
                    else        exp_b.push_back(w);
                end else begin
                    m_v[k] = 1'b0;
                end
            end
            for (int n = 0; n < 4; n++) begin
                if (load) m_p[k][n] = smp[n];
                if (refresh)   m_d[k][n] = 1'b1;
                else if (load) m_d[k][n] = (k == 1) || (smp[n] != m_s[k][n]);
            end
        end
    endtask

    task automatic mon_one(int k, logic [15:0] ins, logic v, logic b);
        logic [15:0] w;
        string tag = (k == 0) ? "a" : "b";
        chk({"valid_", tag}, 32'(v), 32'(m_v[k]));
        chk({"busy_", tag}, 32'(b), 32'(mbusy(k)));
        if (hold[k]) chk({"hold_", tag}, 32'(ins), 32'(prev[k]));
        if (v && ins_ready) begin
            $display("xfer %s ins=%h", tag, ins);
            if (k == 0) begin
                if (exp_a.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL extra_word_a: got %h required none", ins);
                end else begin
                    w = exp_a.pop_front();
                    chk("word_a", 32'(ins), 32'(w));
                end
                seen_a.push_back(ins);
            end else begin
                if (exp_b.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL extra_word_b: got %h required none", ins);
                end else begin
                    w = exp_b.pop_front();
                    chk("word_b", 32'(ins), 32'(w));
                end
                seen_b.push_back(ins);
            end
        end
        hold[k] = v && !ins_ready;
        prev[k] = ins;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            hold[0] = 1'b0;
            hold[1] = 1'b0;
        end else begin
            mon_one(0, if_a.ins, if_a.ins_valid, busy_a);
            mon_one(1, if_b.ins, if_b.ins_valid, busy_b);
        end
    end

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic wait_idle(string nm);
        int n = 0;
        while ((busy_a || busy_b) && n < 60) begin
            step();
            n++;
        end
        chk({nm, ".idle"}, 32'(busy_a | busy_b), 32'd0);
    endtask

    task automatic chk_seen(string nm, input logic [15:0] got[$], input logic [15:0] req[$]);
        chk({nm, ".count"}, 32'(got.size()), 32'(req.size()));
        for (int j = 0; j < req.size(); j++) begin
            if (j < got.size()) chk($sformatf("%s[%0d]", nm, j), 32'(got[j]), 32'(req[j]));
        end
    endtask

    task automatic do_reset(string nm);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk({nm, ".ins_a"}, 32'(if_a.ins), 32'd0);
        chk({nm, ".valid_a"}, 32'(if_a.ins_valid), 32'd0);
        chk({nm, ".busy_a"}, 32'(busy_a), 32'd0);
        chk({nm, ".ins_b"}, 32'(if_b.ins), 32'd0);
        chk({nm, ".busy_b"}, 32'(busy_b), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic do_load();
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    initial begin
        logic [15:0] e[$];
        model_reset();
        #12;
        chk("reset.ins", 32'(if_a.ins), 32'd0);
        chk("reset.valid", 32'(if_a.ins_valid), 32'd0);
        chk("reset.busy", 32'(busy_a), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Only changed channels are sent, with a one-edge gap after load.
        ins_ready = 1'b1;
        i1 = 12'h123; i2 = 12'h000; i3 = 12'hABC; i4 = 12'h000;
        seen_a.delete();
        do_load();
        chk("t1.latency_valid", 32'(if_a.ins_valid), 32'd0);
        step();
        chk("t1.first_valid", 32'(if_a.ins_valid), 32'd1);
        chk("t1.first_ins", 32'(if_a.ins), 32'h0123);
        wait_idle("t1");
        e = '{16'h0123, 16'h2ABC};
        chk_seen("t1.words", seen_a, e);

        // Backpressure: the first word holds; an overwritten pending value is sent once.
        ins_ready = 1'b0;
        i1 = 12'h001; i2 = 12'h111;
        seen_a.delete();
        do_load();
        step();
        for (int j = 0; j < 5; j++) begin
            chk("t2.held_ins", 32'(if_a.ins), 32'h0001);
            step();
        end
        i2 = 12'h222;
        do_load();
        ins_ready = 1'b1;
        wait_idle("t2");
        e = '{16'h0001, 16'h1222};
        chk_seen("t2.words", seen_a, e);

        // Refresh resends everything starting from the round-robin pointer.
        seen_a.delete();
        refresh = 1'b1;
        step();
        refresh = 1'b0;
        wait_idle("t3");
        e = '{16'h2ABC, 16'h3000, 16'h0001, 16'h1222};
        chk_seen("t3.words", seen_a, e);

        // A pending value reverted to its shadow is dropped.
        ins_ready = 1'b0;
        i1 = 12'h456;
        seen_a.delete();
        do_load();
        step();
        i4 = 12'h055;
        do_load();
        i4 = 12'h000;
        do_load();
        ins_ready = 1'b1;
        wait_idle("t4");
        e = '{16'h0456};
        chk_seen("t4.words", seen_a, e);

        // Reset while a word is held under backpressure.
        ins_ready = 1'b0;
        i1 = 12'h777;
        do_load();
        step();
        do_reset("t5.reset");
        for (int j = 0; j < 5; j++) begin
            step();
            chk("t5.quiet_valid", 32'(if_a.ins_valid), 32'd0);
        end

        // Send-all mode emits all four channels on every load.
        ins_ready = 1'b1;
        i1 = 12'h321; i2 = 12'h654; i3 = 12'h987; i4 = 12'hCBA;
        seen_a.delete();
        seen_b.delete();
        do_load();
        wait_idle("t6a");
        do_load();
        wait_idle("t6b");
        e = '{16'h0321, 16'h1654, 16'h2987, 16'h3CBA, 16'h0321, 16'h1654, 16'h2987, 16'h3CBA};
        chk_seen("t6.words_b", seen_b, e);
        e = '{16'h0321, 16'h1654, 16'h2987, 16'h3CBA};
        chk_seen("t6.words_a", seen_a, e);

        // Randomised traffic against the model, with one asynchronous reset.
        for (int cyc = 0; cyc < 400; cyc++) begin
            ins_ready = ($urandom_range(0, 9) < 7);
            load      = ($urandom_range(0, 9) < 2);
            refresh   = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 1) == 1) i1 = ($urandom_range(0, 1) == 1) ? 12'($urandom) : 12'h000;
            if ($urandom_range(0, 1) == 1) i2 = ($urandom_range(0, 1) == 1) ? 12'($urandom) : 12'h055;
            if ($urandom_range(0, 1) == 1) i3 = 12'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) i4 = 12'($urandom);
            if (cyc == 200) begin
                do_reset("rand.reset");
            end else begin
                step();
            end
        end
        load = 1'b0;
        refresh = 1'b0;
        ins_ready = 1'b1;
        wait_idle("drain");
        chk("drain.pending_a", 32'(exp_a.size()), 32'd0);
        chk("drain.pending_b", 32'(exp_b.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ins_encoder.md
# ins_encoder

Parameter-update encoder that packs four 12-bit parameter values into 16-bit instruction words and streams them one per transfer. It is the transmit side of the instruction format consumed by the four-output decoder. Word layout: ins[15:14] = 2'b00, ins[13:12] = channel code, ins[11:0] = data. Channel 1..4 maps to code 0..3. Only changed channels are sent by default, in round-robin order.

## Interface

Parameters:
- CHANGE_ONLY, default 1: 1 = `load` marks a channel pending only if its sample differs from the last value sent on that channel; 0 = `load` marks all four channels pending.

Ports:
- clk  input  1  single clock; all state updates on its rising edge
- rst  input  1  reset, asynchronous and active-high
- i1, i2, i3, i4  input  12 each  parameter values for channels 1..4 (codes 0..3)
- load  input  1  sample i1..i4 this edge
- refresh  input  1  force all four channels pending (resend)
- ins  output  16  instruction word; stable while ins_valid=1 and ins_ready=0
- ins_valid  output  1  ins holds a word to transfer
- ins_ready  input  1  downstream accepts; transfer = ins_valid & ins_ready at an edge
- busy  output  1  ins_valid | any channel pending

## Operation

- Per-channel state: pending value p_n (12b), dirty_n, shadow s_n (last value committed to the output register), plus a round-robin pointer rr (2b, channel code to search from).
- Output stage, two states:
  - IDLE: ins_valid=0.
  - SEND: ins_valid=1.
- Selection, evaluated on the edge leaving IDLE or on a transfer edge in SEND:
  - Pick the first dirty channel at or after rr, circular order 0,1,2,3.
  - If one is found: ins <= {2'b00, code, p_code}; s_code <= p_code; clear dirty_code; rr <= code+1 (mod 4); state SEND.
  - On a transfer edge with nothing dirty: state IDLE; ins keeps its last value.
  - SEND with ins_ready=0: hold ins, ins_valid, rr.
- Selection always uses pre-edge p/dirty.
- `load` edge, all channels:
  - p_n <= i_n.
  - dirty_n <= (CHANGE_ONLY==0) | (i_n != s_n'), where s_n' is the shadow after this edge's selection.
  - A pending value that reverts to its shadow is therefore dropped.
  - A value overwritten before selection is sent once, newest only.
- `refresh` edge: every dirty_n <= 1. If `load` is also high, p takes the new samples. refresh takes priority over the load compare. It overrides a same-edge selection clear.
- No load and no refresh: dirty_n <= dirty_n & ~selected_n.

## Timing

- Reset (async, any time, including mid-transfer):
  - Outputs: ins=16'h0000, ins_valid=0, busy=0.
  - State: p=0, s=0, dirty=0, rr=0, state IDLE.
  - Any word in flight is discarded.
- Latency: `load` sampled at edge E sets dirty after E. The first word appears after E+1 (ins_valid high), regardless of ins_ready.
- Throughput: one word per cycle while ins_ready=1 and channels remain dirty. There are no bubbles between back-to-back words.
- busy updates with the registers; it falls on the edge after the last transfer when no channel is dirty.
- ins[15:14] is always 0.

## Test plan

- Reset: assert rst mid-SEND with ins_ready=0 -> immediately ins=0, ins_valid=0, busy=0. No word is emitted after release until the next load or refresh.
- CHANGE_ONLY=1, ins_ready=1, load i1=12'h123, i2=0, i3=12'hABC, i4=0 -> ins=16'h0123, then 16'h2ABC on the next cycle; then ins_valid=0 and busy=0.
- Backpressure:
  - Setup: ins_ready=0, load i1=12'h001, i2=12'h111; ins=16'h0001 held for 5 cycles.
  - Then load i2=12'h222 and raise ins_ready -> 16'h0001, then 16'h1222. 12'h111 is never sent.
- Round-robin: after a send on channel 2 (rr=2), refresh with ready=1 -> codes in order 2,3,0,1, i.e. 0x2xxx, 0x3xxx, 0x0xxx, 0x1xxx.
- Revert: ins_ready=0 while channel 1 occupies the output; load i4=12'h055 (s4=0), then load i4=0 -> after ready, only the channel-1 word is sent, nothing with code 3.
- CHANGE_ONLY=0: load identical values twice with ready=1 -> four words per load, 8 transfers total, each with the correct code and data.
